scc_mapper_ctrl: RTL
====================

Name: scc_mapper_ctrl

Overview:
- Konami SCC cartridge mapper and bus sequencer, sitting between the MSX cartridge bus and two resources: the IKASCC sound core (ip_ikascc_wrapper) and the cartridge ROM memory port.
- Synchronises the asynchronous slot strobes and decodes each bus cycle.
- Holds the four 8 KB bank registers, routes each access to ROM (req/ack handshake), the SCC register window, or nowhere, and drives the read data back onto the bus.

Parameters:
- BANK_BITS, 6, bank register width; ROM size is 2^(BANK_BITS+13) bytes.
- SCC_BANK, 6'h3F, bank-2 value that opens the SCC window.

Ports:
- clk  in  1  system clock (single clock domain).
- n_reset  in  1  asynchronous active-low reset.
- n_tsltsl  in  1  slot select, asynchronous, active low.
- n_trd  in  1  read strobe, asynchronous, active low.
- n_twr  in  1  write strobe, asynchronous, active low.
- ta  in  16  bus address; stable while a strobe is low.
- wdata  in  8  bus write data.
- rdata  out  8  read data to bus.
- rdata_en  out  1  drive-enable for rdata.
- mem_req  out  1  ROM read request; level signal.
- mem_ack  in  1  ROM data valid; one-cycle pulse.
- mem_addr  out  BANK_BITS+13  ROM byte address.
- mem_rdata  in  8  ROM data; valid with mem_ack.
- scc_wr  out  1  one-cycle SCC write strobe.
- scc_rd  out  1  one-cycle SCC read strobe.
- scc_addr  out  8  SCC register offset, ta[7:0].
- scc_wdata  out  8  SCC write data.
- scc_rdata  in  8  SCC read data; valid the cycle after scc_rd.

Behaviour:
- Reset values:
  - rdata=0, rdata_en=0, mem_req=0, mem_addr=0, scc_wr=0, scc_rd=0, scc_addr=0, scc_wdata=0.
  - bank0..3 = 0,1,2,3. FSM = IDLE. Synchronisers = 1.
- Synchronisation: n_tsltsl, n_trd and n_twr each pass through two flip-flops. sel = !sync_tsltsl.
- Address and data capture: ta and wdata are latched on the cycle the FSM leaves IDLE.
- Page decode: ta[15:13]=2..5 select bank0..bank3; anything else is unmapped.
- scc_hit: bank2==SCC_BANK and ta[15:8]==8'h98.
- IDLE:
  - sel & read → RD_DEC.
  - sel & write & !read → WR_DEC.
  - read and write both low → treated as a read; the write is ignored.
- RD_DEC:
  - scc_hit → scc_rd=1 for one cycle → SCC_RD.
  - Mapped page → mem_addr={bankN, ta[12:0]}, mem_req=1 → MEM_WAIT.
  - Unmapped → HOLD with rdata_en=0.
- MEM_WAIT:
  - Stays until mem_ack=1.
  - On mem_ack: rdata<=mem_rdata, rdata_en<=1, mem_req<=0 in the same cycle → HOLD.
  - A mem_ack that arrives while mem_req=0 is ignored.
- SCC_RD: rdata<=scc_rdata, rdata_en<=1 → HOLD.
- WR_DEC (exactly one action):
  - ta[15:11] = 5'b01010, 5'b01110, 5'b10010, 5'b10110 → bank0, bank1, bank2, bank3 <= wdata[BANK_BITS-1:0].
  - Else scc_hit → scc_wr=1 for one cycle, with scc_addr and scc_wdata.
  - Else ignored (ROM area).
  - Then → HOLD.
  - scc_hit is evaluated with the bank2 value from before the write.
- HOLD:
  - rdata_en stays as set.
  - When sel=0, or both sync_trd and sync_twr are high: rdata_en=0 → IDLE.
  - At most one action per bus cycle; no retrigger while strobes stay low.
- Latency:
  - Strobe to FSM start: 2–3 clocks.
  - SCC read data: 2 clocks after leaving IDLE.
  - ROM read data: mem_ack + 1 clock.
- Reset mid-operation: everything returns immediately to reset values, including mem_req=0.
  - An outstanding mem_ack is then ignored.
  - Bank registers revert to 0..3.

Decomposition:
- Package scc_mapper_pkg:
  - state enum (IDLE, RD_DEC, WR_DEC, MEM_WAIT, SCC_RD, HOLD);
  - page constants;
  - bank-register write-address constants;
  - SCC window constant 8'h98.
- Sub-module msx_bus_sync: 2-FF synchroniser for the three strobes, reset to 1. All other logic lives in the top module.

Test Plan:
- Reset, then read 4000h, with the memory model returning 5Ah after 4 clocks → mem_addr=0000h, rdata=5Ah, rdata_en=1 until n_trd rises, then 0.
- Write 7000h=05h, then read 6123h → mem_addr=0A123h.
- Write 9000h=3Fh, then write 9845h=A7h → exactly one scc_wr pulse with scc_addr=45h and scc_wdata=A7h; no mem_req.
- With bank2=3Fh, read 9880h with scc_rdata=C3h → one scc_rd pulse, rdata=C3h; with bank2=02h the same read gives mem_req with mem_addr=05880h.
- Read C000h with slot selected → no mem_req, no scc_rd, rdata_en=0 throughout; write 4000h=FFh → banks unchanged.
- Assert n_reset low during MEM_WAIT → mem_req=0 and rdata_en=0 immediately, bank3 reads back 3; a late mem_ack causes no rdata_en.

Source files
------------

// File: rtl/scc_mapper_pkg.sv
// Shared types and address constants for the Konami SCC mapper controller.
package scc_mapper_pkg;

    // Bus-cycle sequencer states
    typedef enum logic [2:0] {
        IDLE,
        RD_DEC,
        WR_DEC,
        MEM_WAIT,
        SCC_RD,
        HOLD
    } state_t;

    // ta[15:13] values of the four 8 KB mapper pages (4000h, 6000h, 8000h, A000h)
    localparam logic [2:0] PAGE_BANK0 = 3'd2;
    localparam logic [2:0] PAGE_BANK1 = 3'd3;
    localparam logic [2:0] PAGE_BANK2 = 3'd4;
    localparam logic [2:0] PAGE_BANK3 = 3'd5;

    // ta[15:11] values of the bank-register write windows (5000h, 7000h, 9000h, B000h)
    localparam logic [4:0] BANK0_WADDR = 5'b01010;
    localparam logic [4:0] BANK1_WADDR = 5'b01110;
    localparam logic [4:0] BANK2_WADDR = 5'b10010;
    localparam logic [4:0] BANK3_WADDR = 5'b10110;

    // ta[15:8] of the SCC register window (9800h-98FFh)
    localparam logic [7:0] SCC_WINDOW = 8'h98;

    // True when the page field falls inside one of the four mapped pages
    function automatic logic page_mapped(input logic [2:0] page);
        return (page == PAGE_BANK0) || (page == PAGE_BANK1) ||
               (page == PAGE_BANK2) || (page == PAGE_BANK3);
    endfunction

    // Bank register index serving a mapped page; unmapped pages return 0
    function automatic logic [1:0] page_bank(input logic [2:0] page);
        case (page)
            PAGE_BANK0: return 2'd0;
            PAGE_BANK1: return 2'd1;
            PAGE_BANK2: return 2'd2;
            PAGE_BANK3: return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/msx_bus_sync.sv
// Two-flop synchroniser for the asynchronous MSX slot strobes.
// Flops reset to 1 so the strobes read as inactive coming out of reset.
module msx_bus_sync (
    input  logic clk,
    input  logic n_reset,
    input  logic n_tsltsl,
    input  logic n_trd,
    input  logic n_twr,
    output logic sync_tsltsl,
    output logic sync_trd,
    output logic sync_twr
);

    logic [2:0] meta;
    logic [2:0] sync;

    // Metastability stage followed by the stable stage
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            meta <= 3'b111;
            sync <= 3'b111;
        end else begin
            meta <= {n_tsltsl, n_trd, n_twr};
            sync <= meta;
        end
    end

    assign sync_tsltsl = sync[2];
    assign sync_trd    = sync[1];
    assign sync_twr    = sync[0];

endmodule

// File: rtl/scc_mapper_ctrl.sv
// Konami SCC mapper and bus sequencer: decodes each MSX bus cycle into a
// bank-register write, an SCC register access or a ROM read, and returns
// the read data to the bus. One action per bus cycle.
module scc_mapper_ctrl
    import scc_mapper_pkg::*;
#(
    parameter int                   BANK_BITS = 6,
    parameter logic [BANK_BITS-1:0] SCC_BANK  = BANK_BITS'(6'h3F)
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    n_tsltsl,
    input  logic                    n_trd,
    input  logic                    n_twr,
    input  logic [15:0]             ta,
    input  logic [7:0]              wdata,
    output logic [7:0]              rdata,
    output logic                    rdata_en,
    output logic                    mem_req,
    input  logic                    mem_ack,
    output logic [BANK_BITS+12:0]   mem_addr,
    input  logic [7:0]              mem_rdata,
    output logic                    scc_wr,
    output logic                    scc_rd,
    output logic [7:0]              scc_addr,
    output logic [7:0]              scc_wdata,
    input  logic [7:0]              scc_rdata
);

    logic sync_tsltsl;
    logic sync_trd;
    logic sync_twr;

    msx_bus_sync u_sync (
        .clk         (clk),
        .n_reset     (n_reset),
        .n_tsltsl    (n_tsltsl),
        .n_trd       (n_trd),
        .n_twr       (n_twr),
        .sync_tsltsl (sync_tsltsl),
        .sync_trd    (sync_trd),
        .sync_twr    (sync_twr)
    );

    state_t               state;
    logic [15:0]          addr_q;
    logic [7:0]           wdata_q;
    logic [BANK_BITS-1:0] bank [4];

    logic       sel;
    logic       rd_low;
    logic       wr_low;
    logic       mapped;
    logic [1:0] bank_idx;
    logic       scc_hit;

    assign sel    = !sync_tsltsl;
    assign rd_low = !sync_trd;
    assign wr_low = !sync_twr;

    // Decode of the latched address; scc_hit sees bank2 before any write this cycle
    assign mapped   = page_mapped(addr_q[15:13]);
    assign bank_idx = page_bank(addr_q[15:13]);
    assign scc_hit  = (bank[2] == SCC_BANK) && (addr_q[15:8] == SCC_WINDOW);

    // Bus-cycle sequencer with bank registers and registered bus/ROM/SCC outputs
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata     <= '0;
            rdata_en  <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            scc_wr    <= 1'b0;
            scc_rd    <= 1'b0;
            scc_addr  <= '0;
            scc_wdata <= '0;
            for (int i = 0; i < 4; i++) begin
                bank[i] <= BANK_BITS'(i);
            end
        end else begin
            // SCC strobes are single-cycle pulses
            scc_wr <= 1'b0;
            scc_rd <= 1'b0;

            case (state)
                IDLE: begin
                    // A cycle with both strobes low is serviced as a read
                    if (sel && rd_low) begin
                        addr_q  <= ta;
                        wdata_q <= wdata;
                        state   <= RD_DEC;
                    end else if (sel && wr_low) begin
                        addr_q  <= ta;
                        wdata_q <= wdata;
                        state   <= WR_DEC;
                    end
                end

                RD_DEC: begin
                    if (scc_hit) begin
                        scc_rd   <= 1'b1;
                        scc_addr <= addr_q[7:0];
                        state    <= SCC_RD;
                    end else if (mapped) begin
                        mem_addr <= {bank[bank_idx], addr_q[12:0]};
                        mem_req  <= 1'b1;
                        state    <= MEM_WAIT;
                    end else begin
                        rdata_en <= 1'b0;
                        state    <= HOLD;
                    end
                end

                MEM_WAIT: begin
                    if (mem_ack) begin
                        rdata    <= mem_rdata;
                        rdata_en <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= HOLD;
                    end
                end

                SCC_RD: begin
                    rdata    <= scc_rdata;
                    rdata_en <= 1'b1;
                    state    <= HOLD;
                end

                WR_DEC: begin
                    // Bank windows take priority over the SCC window
                    case (addr_q[15:11])
                        BANK0_WADDR: bank[0] <= wdata_q[BANK_BITS-1:0];
                        BANK1_WADDR: bank[1] <= wdata_q[BANK_BITS-1:0];
                        BANK2_WADDR: bank[2] <= wdata_q[BANK_BITS-1:0];
                        BANK3_WADDR: bank[3] <= wdata_q[BANK_BITS-1:0];
                        default: begin
                            if (scc_hit) begin
                                scc_wr    <= 1'b1;
                                scc_addr  <= addr_q[7:0];
                                scc_wdata <= wdata_q;
                            end
                        end
                    endcase
                    state <= HOLD;
                end

                HOLD: begin
                    // Wait for the bus cycle to end so a long strobe cannot retrigger
                    if (!sel || (sync_trd && sync_twr)) begin
                        rdata_en <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
